// File: rtl/window_3x3_gen_pkg.sv
// window_3x3_gen_pkg: pipeline-wide image defaults and window geometry shared by the 3x3 window generator.
package window_3x3_gen_pkg;
  localparam int IMG_W_DEF = 256;
  localparam int IMG_H_DEF = 256;
  localparam int PIX_W_DEF = 17;
  localparam int WIN_ROW = 3;
  localparam int WIN_N = WIN_ROW * WIN_ROW;
endpackage

// File: rtl/window_3x3_gen_line_ram.sv
// line_ram: single-address row buffer, combinational read and synchronous write, so a same-edge write sees the old word.
module line_ram
  import window_3x3_gen_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int W = PIX_W_DEF,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  assign rdata = mem[addr];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
endmodule

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: raster pixel stream to registered interior 3x3 neighbourhoods with centre coordinates.
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             win_valid,
  output logic [PIX_W-1:0] p0,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p4,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic [XW-1:0]    out_x,
  output logic [YW-1:0]    out_y,
  output logic             frame_done
);
  logic [XW-1:0] col_q, col_d, cur_c;
  logic [YW-1:0] row_q, row_d, cur_r;
  logic [PIX_W-1:0] a, b;
  logic [PIX_W-1:0] nw [WIN_ROW];
  logic [PIX_W-1:0] s_q [WIN_N];
  logic [PIX_W-1:0] s_d [WIN_N];
  logic [PIX_W-1:0] p_q [WIN_N];
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic last_c, last_r, win_d, done_d, win_q, done_q;
  // An accepted sof pixel is placed at (0,0) whatever the counters say.
  always_comb begin
    cur_c = in_sof ? '0 : col_q;
    cur_r = in_sof ? '0 : row_q;
    last_c = cur_c == XW'(IMG_W - 1);
    last_r = cur_r == YW'(IMG_H - 1);
    col_d = !in_valid ? col_q : last_c ? '0 : cur_c + XW'(1);
    row_d = !in_valid ? row_q : !last_c ? cur_r : last_r ? '0 : cur_r + YW'(1);
    win_d = in_valid && cur_c >= XW'(2) && cur_r >= YW'(2);
    done_d = in_valid && last_c && last_r;
    nw[0] = b;
    nw[1] = a;
    nw[2] = in_pixel;
    for (int i = 0; i < WIN_ROW; i++) begin
      s_d[WIN_ROW*i]   = s_q[WIN_ROW*i+1];
      s_d[WIN_ROW*i+1] = s_q[WIN_ROW*i+2];
      s_d[WIN_ROW*i+2] = nw[i];
    end
  end
  line_ram #(.DEPTH(IMG_W), .W(PIX_W)) lb1 (
    .clk(clk), .we(in_valid && !rst), .addr(cur_c), .wdata(in_pixel), .rdata(a)
  );
  line_ram #(.DEPTH(IMG_W), .W(PIX_W)) lb2 (
    .clk(clk), .we(in_valid && !rst), .addr(cur_c), .wdata(a), .rdata(b)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      s_q <= '{default: '0};
      p_q <= '{default: '0};
      x_q <= '0;
      y_q <= '0;
      win_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      done_q <= done_d;
      if (in_valid) s_q <= s_d;
      if (win_d) begin
        p_q <= s_d;
        x_q <= cur_c - XW'(1);
        y_q <= cur_r - YW'(1);
      end
    end
  end
  assign win_valid = win_q;
  assign frame_done = done_q;
  assign out_x = x_q;
  assign out_y = y_q;
  assign {p8, p7, p6, p5, p4, p3, p2, p1, p0} =
    {p_q[8], p_q[7], p_q[6], p_q[5], p_q[4], p_q[3], p_q[2], p_q[1], p_q[0]};
endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: table-driven and scoreboard checks of the 3x3 window generator on an 8x4 image.
module tb_window_3x3_gen;
  localparam int W = 8, H = 4, PW = 17;
  logic clk = 0, rst = 0, in_valid = 0, in_sof = 0;
  logic [PW-1:0] in_pixel = '0;
  logic win_valid, frame_done;
  logic [PW-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic [2:0] out_x;
  logic [1:0] out_y;
  logic [8:0][PW-1:0] gp;
  assign gp = {p8, p7, p6, p5, p4, p3, p2, p1, p0};

  window_3x3_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .win_valid(win_valid), .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5),
    .p6(p6), .p7(p7), .p8(p8), .out_x(out_x), .out_y(out_y), .frame_done(frame_done)
  );
  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0][PW-1:0] p;
    logic [2:0] x;
    logic [1:0] y;
  } win_t;
  typedef struct {
    logic v; logic s; int pix;
    logic ew; int ex; int ey; int ep0; int ep8; logic ed;
  } vec_t;

  win_t q[$];
  vec_t tbl[32];
  int img[H][W];
  int mc = 0, mr = 0;
  int checks = 0, errors = 0;
  int wins = 0, dones = 0;
  logic [8:0][PW-1:0] first_p, last_p;
  int first_x, first_y, last_x, last_y;
  logic last_co;

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // One clock: drive inputs, update the image model, then compare after the edge.
  task automatic step(input bit r, input bit v, input bit s, input int pix);
    logic ed;
    win_t e;
    ed = 0;
    rst = r; in_valid = v; in_sof = s; in_pixel = PW'(pix);
    if (r) begin
      mc = 0; mr = 0;
      q.delete();
    end else if (v) begin
      if (s) begin mc = 0; mr = 0; end
      img[mr][mc] = pix;
      if (mc >= 2 && mr >= 2) begin
        for (int k = 0; k < 9; k++) e.p[k] = PW'(img[mr-2+k/3][mc-2+k%3]);
        e.x = 3'(mc - 1);
        e.y = 2'(mr - 1);
        q.push_back(e);
      end
      ed = (mc == W-1 && mr == H-1);
      mc++;
      if (mc == W) begin mc = 0; mr = (mr == H-1) ? 0 : mr + 1; end
    end
    @(posedge clk);
    #1;
    if (r) begin
      chk("rst_win_valid", win_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_out_x", out_x, 0);
      chk("rst_out_y", out_y, 0);
      for (int k = 0; k < 9; k++) chk("rst_p", gp[k], 0);
    end else begin
      chk("frame_done", frame_done, ed);
      chk("win_valid", win_valid, q.size() > 0);
      if (win_valid && q.size() > 0) begin
        e = q.pop_front();
        for (int k = 0; k < 9; k++) chk("win_p", gp[k], e.p[k]);
        chk("win_x", out_x, e.x);
        chk("win_y", out_y, e.y);
      end
      q.delete();
      if (frame_done) begin dones++; last_co = win_valid; end
      if (win_valid) begin
        if (wins == 0) begin first_p = gp; first_x = out_x; first_y = out_y; end
        last_p = gp; last_x = out_x; last_y = out_y;
        wins++;
      end
    end
  endtask

  task automatic run_frame(input int off, input bit bub);
    wins = 0; dones = 0;
    for (int i = 0; i < W*H; i++) begin
      step(0, 1, i == 0, off + 16*(i/W) + i%W);
      if (bub) step(0, 0, 1, 999);
    end
  endtask

  initial begin
    for (int i = 0; i < W*H; i++) begin
      tbl[i].v = 1;
      tbl[i].s = (i == 0);
      tbl[i].pix = 16*(i/W) + i%W;
      tbl[i].ew = (i%W >= 2) && (i/W >= 2);
      tbl[i].ex = i%W - 1;
      tbl[i].ey = i/W - 1;
      tbl[i].ep0 = 16*(i/W - 2) + i%W - 2;
      tbl[i].ep8 = tbl[i].pix;
      tbl[i].ed = (i == W*H-1);
    end
    repeat (3) step(1, 0, 0, 0);

    wins = 0; dones = 0;
    for (int i = 0; i < W*H; i++) begin
      step(0, tbl[i].v, tbl[i].s, tbl[i].pix);
      chk("tbl_win", win_valid, tbl[i].ew);
      chk("tbl_done", frame_done, tbl[i].ed);
      if (tbl[i].ew) begin
        chk("tbl_x", out_x, tbl[i].ex);
        chk("tbl_y", out_y, tbl[i].ey);
        chk("tbl_p0", p0, tbl[i].ep0);
        chk("tbl_p8", p8, tbl[i].ep8);
      end
    end
    chk("first_p0", first_p[0], 0); chk("first_p1", first_p[1], 1);
    chk("first_p2", first_p[2], 2); chk("first_p3", first_p[3], 16);
    chk("first_p4", first_p[4], 17); chk("first_p5", first_p[5], 18);
    chk("first_p6", first_p[6], 32); chk("first_p7", first_p[7], 33);
    chk("first_p8", first_p[8], 34);
    chk("first_x", first_x, 1); chk("first_y", first_y, 1);
    chk("cont_wins", wins, 12);
    chk("last_p8", last_p[8], 55); chk("last_x", last_x, 6); chk("last_y", last_y, 2);
    chk("cont_dones", dones, 1); chk("done_with_win", last_co, 1);

    run_frame(0, 1);
    chk("bub_wins", wins, 12);
    chk("bub_last_p8", last_p[8], 55);
    chk("bub_dones", dones, 1);

    run_frame(100, 0);
    chk("b2b_p0", first_p[0], 100);
    chk("b2b_p8", first_p[8], 134);
    chk("b2b_wins", wins, 12);

    wins = 0; dones = 0;
    for (int i = 0; i < 21; i++) step(0, 1, i == 0, 16*(i/W) + i%W);
    chk("abort_wins", wins, 3);
    step(0, 1, 1, 200);
    chk("sof_no_win", win_valid, 0);
    chk("abort_no_done", dones, 0);
    wins = 0;
    for (int i = 1; i < W*H; i++) step(0, 1, 0, 16*(i/W) + i%W);
    chk("sof_wins", wins, 12);
    chk("sof_first_p0", first_p[0], 200);
    chk("sof_first_x", first_x, 1);
    chk("sof_first_y", first_y, 1);
    chk("sof_dones", dones, 1);

    for (int i = 0; i < 20; i++) step(0, 1, i == 0, 16*(i/W) + i%W);
    step(1, 1, 0, 36);
    wins = 0; dones = 0;
    for (int i = 0; i < W*H; i++) step(0, 1, 0, 16*(i/W) + i%W);
    chk("rst_frame_wins", wins, 12);
    chk("rst_frame_p0", first_p[0], 0);
    chk("rst_frame_p4", first_p[4], 17);
    chk("rst_frame_p8", first_p[8], 34);
    chk("rst_frame_x", first_x, 1);
    chk("rst_frame_y", first_y, 1);
    chk("rst_frame_dones", dones, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
